// File: rtl/sum_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sum_pkg
//  Description : Shared definitions for the serial wide adder: FSM state
//                encoding and the slice-counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package sum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of a counter that walks 0..m-1; never narrower than one bit so
    // the single-slice configuration still has a legal counter.
    function automatic int cnt_width(input int m);
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage : sum_pkg
`default_nettype wire

// File: rtl/sum_Nbit.sv
`default_nettype none
// ============================================================================
//  Module      : sum_Nbit
//  Description : Combinational N-bit adder with carry-in and carry-out.
//  Revision    : 1.0 - initial release
// ============================================================================
module sum_Nbit #(
    parameter int N = 4
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         ci_i,
    output logic [N-1:0] s_o,
    output logic         co_o
);

    // Widen by one bit so the carry-out falls out of the addition directly.
    assign {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, ci_i};

endmodule : sum_Nbit
`default_nettype wire

// File: rtl/sum_serial_wide.sv
`default_nettype none
// ============================================================================
//  Module      : sum_serial_wide
//  Description : Multi-cycle W-bit adder (W = N*M). One N-bit slice is added
//                per clock through a single sum_Nbit instance, with the slice
//                carry held in a register between slices.
//  Revision    : 1.0 - initial release
// ============================================================================
module sum_serial_wide
    import sum_pkg::*;
#(
    parameter  int N = 4,
    parameter  int M = 4,
    localparam int W = N * M
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] s,
    output logic         co
);

    localparam int CW = cnt_width(M);

    state_t        state_q, state_d;
    logic [CW-1:0] k_q, k_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  work_q, work_d;
    logic [W-1:0]  s_q, s_d;
    logic          co_q, co_d;

    logic [N-1:0]  slice_a;
    logic [N-1:0]  slice_b;
    logic [N-1:0]  slice_s;
    logic          slice_co;
    logic [W-1:0]  work_merged;
    logic          last_slice;

    // Select the operand slice addressed by the counter.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int j = 0; j < M; j++) begin
            if (k_q == CW'(j)) begin
                slice_a = a_q[j*N +: N];
                slice_b = b_q[j*N +: N];
            end
        end
    end

    sum_Nbit #(
        .N    (N)
    ) u_slice_adder (
        .a_i  (slice_a),
        .b_i  (slice_b),
        .ci_i (carry_q),
        .s_o  (slice_s),
        .co_o (slice_co)
    );

    // Work register with the current slice result dropped into place; this is
    // also what gets published on the final slice so s includes it.
    always_comb begin
        work_merged = work_q;
        for (int j = 0; j < M; j++) begin
            if (k_q == CW'(j)) begin
                work_merged[j*N +: N] = slice_s;
            end
        end
    end

    assign last_slice = (k_q == CW'(M - 1));

    // Next-state logic: accept, slice stepping and result publication.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        work_d  = work_q;
        s_d     = s_q;
        co_d    = co_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = ci;
                    k_d     = '0;
                    work_d  = '0;
                    state_d = ST_RUN;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                work_d  = work_merged;
                carry_d = slice_co;
                if (last_slice) begin
                    s_d     = work_merged;
                    co_d    = slice_co;
                    k_d     = '0;
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any addition in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            work_q  <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            work_q  <= work_d;
            s_q     <= s_d;
            co_q    <= co_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign s    = s_q;
    assign co   = co_q;

endmodule : sum_serial_wide
`default_nettype wire

// File: tb/tb_sum_serial_wide.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sum_serial_wide
//  Description : Self-checking bench for sum_serial_wide (N=4, M=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_serial_wide;

    localparam int N = 4;
    localparam int M = 4;
    localparam int W = N * M;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         co;

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] s;
        logic         co;
    } vec_t;

    res_t         sb[$];
    vec_t         vecs[3];
    int           checks;
    int           failures;
    logic [W-1:0] hold_s;
    logic         hold_co;
    logic         prev_done;

    sum_serial_wide #(
        .N     (N),
        .M     (M)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tci);
        logic [W:0] t;
        t = {1'b0, ta} + {1'b0, tb} + (W+1)'(tci);
        return '{s: t[W-1:0], co: t[W]};
    endfunction

    // Result monitor: pops the scoreboard on every done, checks the pulse
    // width and that s/co hold their value between results.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                res_t e;
                if (prev_done) chk("done_width", 32'd2, 32'd1);
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("s", 32'(s), 32'(e.s));
                    chk("co", 32'(co), 32'(e.co));
                    hold_s  = e.s;
                    hold_co = e.co;
                end
            end else begin
                chk("s_hold", 32'(s), 32'(hold_s));
                chk("co_hold", 32'(co), 32'(hold_co));
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    // One addition: accept, scramble inputs, wait for done with a bound.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tci);
        bit found;
        @(negedge clk);
        a     = ta;
        b     = tb;
        ci    = tci;
        start = 1'b1;
        sb.push_back(model(ta, tb, tci));
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        ci    = 1'($urandom);
        chk("busy_after_accept", 32'(busy), 32'd1);
        found = 1'b0;
        for (int i = 1; i <= 20 && !found; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                found = 1'b1;
                chk("latency", 32'(i), 32'(M));
                chk("busy_in_done", 32'(busy), 32'd0);
            end else if (i < M) begin
                chk("busy_run", 32'(busy), 32'd1);
            end
        end
        if (!found) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        checks    = 0;
        failures  = 0;
        hold_s    = '0;
        hold_co   = 1'b0;
        prev_done = 1'b0;
        rst_n     = 1'b0;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        ci        = 1'b0;

        vecs[0] = '{a: 16'h1234, b: 16'h1111, ci: 1'b0, s: 16'h2345, co: 1'b0};
        vecs[1] = '{a: 16'hFFFF, b: 16'h0001, ci: 1'b0, s: 16'h0000, co: 1'b1};
        vecs[2] = '{a: 16'hFFFF, b: 16'hFFFF, ci: 1'b1, s: 16'hFFFF, co: 1'b1};

        // Reset state.
        #7;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_co", 32'(co), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors; expected values are hand-computed in the table
        // and cross-checked against the arithmetic model.
        foreach (vecs[i]) begin
            res_t m;
            m = model(vecs[i].a, vecs[i].b, vecs[i].ci);
            chk("table_model_s", 32'(m.s), 32'(vecs[i].s));
            chk("table_model_co", 32'(m.co), 32'(vecs[i].co));
            run_op(vecs[i].a, vecs[i].b, vecs[i].ci);
        end

        // Reset mid-RUN after two slices: outputs drop at once, no done follows.
        run_op(16'h1234, 16'h1111, 1'b0);
        @(negedge clk);
        a     = 16'h4321;
        b     = 16'h1111;
        ci    = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n   = 1'b0;
        hold_s  = '0;
        hold_co = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_s", 32'(s), 32'd0);
        chk("midrst_co", 32'(co), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        run_op(16'h0F0F, 16'h0101, 1'b1);

        // Start held high; operand changes during RUN are ignored and the
        // second operation is accepted in the DONE cycle.
        @(negedge clk);
        a     = 16'h5555;
        b     = 16'h2222;
        ci    = 1'b1;
        start = 1'b1;
        sb.push_back(model(16'h5555, 16'h2222, 1'b1));
        @(posedge clk);
        found = 1'b0;
        for (int i = 1; i <= 20 && !found; i++) begin
            #1;
            a  = W'($urandom);
            b  = W'($urandom);
            ci = 1'($urandom);
            @(posedge clk);
            #1;
            if (done) begin
                found = 1'b1;
                chk("held_latency", 32'(i), 32'(M));
            end
        end
        if (!found) chk("held_timeout", 32'd0, 32'd1);
        a  = 16'h0F0F;
        b  = 16'h00F1;
        ci = 1'b0;
        sb.push_back('{s: 16'h1000, co: 1'b0});
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_busy", 32'(busy), 32'd1);
        found = 1'b0;
        for (int i = 1; i <= 20 && !found; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                found = 1'b1;
                chk("b2b_latency", 32'(i), 32'(M));
            end
        end
        if (!found) chk("b2b_timeout", 32'd0, 32'd1);

        // Random operands with random gaps (gap 0 starts in the DONE cycle).
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op(W'($urandom), W'($urandom), 1'($urandom));
        end

        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sum_serial_wide
`default_nettype wire
